// File: rtl/antares_divider.sv
// Iterative radix-2 restoring divider (DIV/DIVU), one quotient bit per cycle.
// Optional ANTARES_DIV_EARLY_EN: a zero divisor skips the iteration and completes in one cycle.
module antares_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_divs,
  input  logic             op_divu,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             abort,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_r, quo_r, dvsr_r;
  logic             neg_q, neg_r, dbz_r;

  logic             start, is_signed, load, step, finish, fast;
  logic             a_neg, b_neg, dvsr_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] fin_q_raw, fin_r_raw;
  logic             fin_nq, fin_nr, fin_dbz;

  assign start     = op_divs | op_divu;
  assign is_signed = op_divs;
  assign a_neg     = is_signed & dividend[WIDTH-1];
  assign b_neg     = is_signed & divisor[WIDTH-1];
  assign a_mag     = a_neg ? -dividend : dividend;
  assign b_mag     = b_neg ? -divisor : divisor;
  assign dvsr_zero = (divisor == '0);

`ifdef ANTARES_DIV_EARLY_EN
  assign fast = load & dvsr_zero;
`else
  assign fast = 1'b0;
`endif

  // One restoring step; the extra top bit of trial is the borrow.
  assign shifted = {rem_r, quo_r[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dvsr_r};

  always_comb begin
    if (!trial[WIDTH+1]) begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = shifted[WIDTH-1:0];
      quo_step = {quo_r[WIDTH-2:0], 1'b0};
    end
  end

  // The early zero-divisor path produces the same result the full iteration would.
  assign fin_q_raw = fast ? {WIDTH{1'b1}} : quo_step;
  assign fin_r_raw = fast ? a_mag : rem_step;
  assign fin_nq    = fast ? (a_neg ^ b_neg) : neg_q;
  assign fin_nr    = fast ? a_neg : neg_r;
  assign fin_dbz   = fast ? 1'b1 : dbz_r;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          load      = 1'b1;
          state_nxt = S_BUSY;
`ifdef ANTARES_DIV_EARLY_EN
          if (dvsr_zero) begin
            finish    = 1'b1;
            state_nxt = S_DONE;
          end
`endif
        end
      end
      S_BUSY: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          step = 1'b1;
          if (cnt == CW'(1)) begin
            finish    = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (start) begin
          load      = 1'b1;
          state_nxt = S_BUSY;
`ifdef ANTARES_DIV_EARLY_EN
          if (dvsr_zero) begin
            finish    = 1'b1;
            state_nxt = S_DONE;
          end
`endif
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_BUSY);
      done  <= (state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      dvsr_r      <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (load) begin
        cnt    <= CW'(WIDTH);
        rem_r  <= '0;
        quo_r  <= a_mag;
        dvsr_r <= b_mag;
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        dbz_r  <= dvsr_zero;
      end else if (step) begin
        cnt   <= cnt - CW'(1);
        rem_r <= rem_step;
        quo_r <= quo_step;
      end
      if (finish) begin
        quotient    <= fin_nq ? -fin_q_raw : fin_q_raw;
        remainder   <= fin_nr ? -fin_r_raw : fin_r_raw;
        div_by_zero <= fin_dbz;
      end
    end
  end

endmodule
